// File: rtl/fp_acc_pkg.sv
// Shared types and helpers for the fixed-point accumulator pipeline stages.
package fp_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  // The count must be able to hold LEN itself, because it keeps that value after completion.
  function automatic int cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/std_fp_sat_trunc.sv
// Narrows a guard-extended fixed-point value to WIDTH bits and flags any loss of high bits.
// Build option FP_ACC_SATURATE_EN: when defined, an overflowing value clamps to all ones instead of wrapping.
module std_fp_sat_trunc #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 36
) (
  input  logic [ACC_W-1:0] acc,
  output logic [WIDTH-1:0] value,
  output logic             overflow
);

  if (ACC_W < WIDTH) begin : g_bad_width
    $error("std_fp_sat_trunc: ACC_W (%0d) must be >= WIDTH (%0d)", ACC_W, WIDTH);
  end

  // With no guard bits, nothing can be lost, so overflow is constant zero.
  if (ACC_W > WIDTH) begin : g_guard
    assign overflow = |acc[ACC_W-1:WIDTH];
  end else begin : g_no_guard
    assign overflow = 1'b0;
  end

`ifdef FP_ACC_SATURATE_EN
  assign value = overflow ? '1 : acc[WIDTH-1:0];
`else
  assign value = acc[WIDTH-1:0];
`endif

endmodule

// File: rtl/std_fp_acc_pipe.sv
// Unsigned fixed-point accumulator: sums LEN terms under a go/done handshake and returns one WIDTH-bit result.
// Build option FP_ACC_SATURATE_EN selects saturating output (see std_fp_sat_trunc); the default build wraps.
module std_fp_acc_pipe
  import fp_acc_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int INT_WIDTH  = 16,
  parameter  int FRAC_WIDTH = 16,
  parameter  int LEN        = 8,
  parameter  int GUARD      = 4,
  localparam int CNT_W      = cnt_width(LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done
);

  localparam int ACC_W = WIDTH + GUARD;

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
    $error("std_fp_acc_pipe: INT_WIDTH+FRAC_WIDTH (%0d) != WIDTH (%0d)", INT_WIDTH + FRAC_WIDTH, WIDTH);
  end
  if (LEN < 1) begin : g_bad_len
    $error("std_fp_acc_pipe: LEN (%0d) must be >= 1", LEN);
  end
  if (GUARD < $clog2(LEN)) begin : g_bad_guard
    $error("std_fp_acc_pipe: GUARD (%0d) < clog2(LEN) (%0d), accumulator could wrap", GUARD, $clog2(LEN));
  end

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             beat;
  logic             last_beat;
  logic [WIDTH-1:0] final_value;
  logic             final_overflow;

  assign in_ready  = (state == ACC);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (count == CNT_W'(LEN - 1));
  assign acc_sum   = acc + ACC_W'(in);

  // The result is formed from acc_sum, so the final term is included on the same edge it is accepted.
  std_fp_sat_trunc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_sat_trunc (
    .acc      (acc_sum),
    .value    (final_value),
    .overflow (final_overflow)
  );

  // NOTE: clocked state uses non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      out      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            acc   <= '0;
            count <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          // Abort wins over a coincident beat; acc/count are cleared on the next start anyway.
          if (!go) begin
            state <= IDLE;
          end else if (beat) begin
            acc   <= acc_sum;
            count <= count + 1'b1;
            if (last_beat) begin
              out      <= final_value;
              overflow <= final_overflow;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_fp_acc_pipe.sv
// Self-checking bench: directed handshake/boundary cases plus randomized runs against a queue-based model.
module tb_std_fp_acc_pipe;

  localparam int WIDTH = 32;
  localparam int LEN   = 4;
`ifdef FP_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        go;
  logic        in_valid;
  logic [31:0] din;
  logic        in_ready;
  logic [2:0]  count;
  logic [31:0] dout;
  logic        overflow;
  logic        done;

  logic        go1;
  logic        valid1;
  logic [31:0] din1;
  logic        ready1;
  logic [0:0]  count1;
  logic [31:0] dout1;
  logic        ovf1;
  logic        done1;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  std_fp_acc_pipe #(
    .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .LEN(LEN), .GUARD(4)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .in(din), .in_valid(in_valid),
    .in_ready(in_ready), .count(count), .out(dout), .overflow(overflow), .done(done)
  );

  std_fp_acc_pipe #(
    .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .LEN(1), .GUARD(4)
  ) dut1 (
    .clk(clk), .reset(reset), .go(go1), .in(din1), .in_valid(valid1),
    .in_ready(ready1), .count(count1), .out(dout1), .overflow(ovf1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a run is the list of accepted terms; the result is their plain sum.
  bit              m_running;
  bit              m_done;
  int              m_count;
  logic [31:0]     m_out;
  bit              m_ovf;
  logic [31:0]     m_terms[$];

  function automatic void finish_run();
    longint unsigned s = 0;
    foreach (m_terms[i]) s += 64'(m_terms[i]);
    m_ovf = (s > 64'h0000_0000_FFFF_FFFF);
    m_out = (m_ovf && SAT) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running = 0; m_done = 0; m_count = 0; m_out = '0; m_ovf = 0;
      m_terms.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_running) begin
      if (go) begin
        m_running = 1; m_count = 0;
        m_terms.delete();
      end
    end else if (!go) begin
      m_running = 0;
    end else if (in_valid) begin
      m_terms.push_back(din);
      m_count++;
      if (m_count == LEN) begin
        finish_run();
        m_running = 0;
        m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("in_ready", 64'(in_ready), 64'(m_running));
      check("done",     64'(done),     64'(m_done));
      check("count",    64'(count),    64'(m_count));
      check("out",      64'(dout),     64'(m_out));
      check("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  // Sets the inputs that the next rising edge will sample.
  task automatic step(input logic g, input logic v, input logic [31:0] d);
    @(negedge clk);
    #2;
    go = g; in_valid = v; din = d;
  endtask

  // Edge 0 samples go; pat[k] drives in_valid for edge k+1. Returns the cycle number in which done was seen.
  task automatic run_pattern(input int n, input logic [15:0] pat, input logic [31:0] d, output int done_cyc);
    done_cyc = -1;
    step(1'b1, 1'b0, d);
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_cyc < 0) done_cyc = k + 1;
      #2;
      if (k < n) begin
        go = 1'b1; in_valid = pat[k];
      end else begin
        go = 1'b0; in_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rand_term();
    case ($urandom_range(0, 2))
      0:       return {4'h0, 28'($urandom)};
      1:       return {16'hFFFF, 16'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int dc;
    go = 0; in_valid = 0; din = '0;
    go1 = 0; valid1 = 0; din1 = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_out",      64'(dout),     64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_done",     64'(done),     64'h0);
    check("rst_count",    64'(count),    64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    @(negedge clk); #2;
    reset = 1'b0;
    cmp_en = 1'b1;

    // Test 1: four back-to-back beats of 1.0
    run_pattern(4, 16'h000F, 32'h0001_0000, dc);
    check("t1_done_cycle", 64'(dc),       64'd5);
    check("t1_out",        64'(dout),     64'h0004_0000);
    check("t1_overflow",   64'(overflow), 64'h0);
    check("t1_count",      64'(count),    64'd4);

    // Test 4: abort after two beats, then a full run
    step(1'b1, 1'b0, 32'h0001_0000);
    step(1'b1, 1'b1, 32'h0001_0000);
    step(1'b1, 1'b1, 32'h0001_0000);
    step(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t4_abort_ready", 64'(in_ready), 64'h0);
    check("t4_abort_done",  64'(done),     64'h0);
    check("t4_abort_out",   64'(dout),     64'h0004_0000);
    run_pattern(4, 16'h000F, 32'h0001_0000, dc);
    check("t4_done_cycle", 64'(dc),   64'd5);
    check("t4_out",        64'(dout), 64'h0004_0000);

    // Test 2: bubbles 1,0,0,1,1,0,1
    run_pattern(7, 16'h0059, 32'h0000_8000, dc);
    check("t2_done_cycle", 64'(dc),   64'd8);
    check("t2_out",        64'(dout), 64'h0002_0000);

    // Test 3: overflow
    run_pattern(4, 16'h000F, 32'hFFFF_0000, dc);
    check("t3_done_cycle", 64'(dc),       64'd5);
    check("t3_overflow",   64'(overflow), 64'h1);
    check("t3_out",        64'(dout),     SAT ? 64'hFFFF_FFFF : 64'hFFFC_0000);

    // Test 5: asynchronous reset between edges in the middle of a run
    step(1'b1, 1'b0, 32'h0003_0000);
    step(1'b1, 1'b1, 32'h0003_0000);
    step(1'b1, 1'b1, 32'h0003_0000);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("t5_rst_out",      64'(dout),     64'h0);
    check("t5_rst_overflow", 64'(overflow), 64'h0);
    check("t5_rst_count",    64'(count),    64'h0);
    check("t5_rst_done",     64'(done),     64'h0);
    check("t5_rst_ready",    64'(in_ready), 64'h0);
    @(negedge clk); #2;
    reset = 1'b0; go = 1'b0; in_valid = 1'b0;
    run_pattern(4, 16'h000F, 32'h0003_0000, dc);
    check("t5_done_cycle", 64'(dc),   64'd5);
    check("t5_out",        64'(dout), 64'h000C_0000);

    // Randomized traffic: bubbles, aborts, idle gaps and back-to-back runs
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #2;
      din = rand_term();
      if (m_running) begin
        if ($urandom_range(0, 24) == 0) begin
          go = 1'b0; in_valid = 1'b0;
        end else begin
          go = 1'b1; in_valid = ($urandom_range(0, 3) != 0);
        end
      end else begin
        go = ($urandom_range(0, 3) != 0);
        in_valid = $urandom_range(0, 1) != 0;
      end
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Test 6: LEN=1 instance; in_valid during IDLE is ignored
    valid1 = 1'b1; din1 = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      check("t6_idle_count", 64'(count1), 64'h0);
      check("t6_idle_ready", 64'(ready1), 64'h0);
    end
    #2 go1 = 1'b1;
    @(negedge clk);
    check("t6_c1_ready", 64'(ready1), 64'h1);
    check("t6_c1_done",  64'(done1),  64'h0);
    check("t6_c1_count", 64'(count1), 64'h0);
    @(negedge clk);
    check("t6_c2_done",     64'(done1),  64'h1);
    check("t6_c2_out",      64'(dout1),  64'h1234_5678);
    check("t6_c2_overflow", 64'(ovf1),   64'h0);
    check("t6_c2_count",    64'(count1), 64'h1);
    check("t6_c2_ready",    64'(ready1), 64'h0);
    #2 go1 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    check("t6_c3_done", 64'(done1), 64'h0);
    check("t6_c3_out",  64'(dout1), 64'h1234_5678);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
